// File: rtl/led_breath_pwm_pkg.sv
// Shared types for the LED breathing controller: phase encoding used by the
// breathing state machine and visible on the phase output.
package led_breath_pwm_pkg;

    typedef enum logic [1:0] {
        PH_RAMP_UP   = 2'd0,
        PH_HOLD_HIGH = 2'd1,
        PH_RAMP_DOWN = 2'd2,
        PH_HOLD_LOW  = 2'd3
    } phase_t;

    localparam int HOLD_CNT_BITS = 16;

endpackage

// File: rtl/led_breath_pwm_step_sync.sv
// step_sync: brings a slow divided clock into the clock domain and emits a
// registered one-cycle pulse per edge. LED_BREATH_BOTH_EDGES_EN selects both edges.
module step_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history_q;
    logic                   sync_out;
    logic                   edge_det;

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef LED_BREATH_BOTH_EDGES_EN
    assign edge_det = sync_out ^ history_q;
`else
    assign edge_det = sync_out & ~history_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            history_q <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            history_q <= sync_out;
            pulse     <= edge_det;
        end
    end

endmodule

// File: rtl/led_breath_pwm.sv
// LED breathing controller: triangle brightness ramp stepped by a synchronised
// divided clock, driving a free-running PWM. Optional macro: LED_BREATH_BOTH_EDGES_EN.
//
//   state        | meaning
//   PH_RAMP_UP   | level +1 per step until full
//   PH_HOLD_HIGH | stay at full for HOLD_STEPS steps
//   PH_RAMP_DOWN | level -1 per step until off
//   PH_HOLD_LOW  | stay off for HOLD_STEPS steps
module led_breath_pwm
    import led_breath_pwm_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int HOLD_STEPS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                step_clock,
    output logic                step_pulse,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0]      LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0]      LEVEL_ONE = PWM_BITS'(1);
    localparam logic [HOLD_CNT_BITS-1:0] HOLD_LAST = HOLD_CNT_BITS'(HOLD_STEPS - 1);

    logic                     sync_pulse;
    phase_t                   state_q;
    logic [HOLD_CNT_BITS-1:0] hold_cnt;
    logic [PWM_BITS-1:0]      pwm_cnt;

    step_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (step_clock),
        .pulse    (sync_pulse)
    );

    // Extra stage places step_pulse SYNC_STAGES+1 edges after the capturing edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= sync_pulse;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PH_RAMP_UP;
            level    <= '0;
            hold_cnt <= '0;
        end else if (step_pulse && enable) begin
            case (state_q)
                PH_RAMP_UP: begin
                    level <= level + LEVEL_ONE;
                    if (level == LEVEL_MAX - LEVEL_ONE) begin
                        state_q  <= PH_HOLD_HIGH;
                        hold_cnt <= '0;
                    end
                end
                PH_HOLD_HIGH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_q  <= PH_RAMP_DOWN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                PH_RAMP_DOWN: begin
                    level <= level - LEVEL_ONE;
                    if (level == LEVEL_ONE) begin
                        state_q  <= PH_HOLD_LOW;
                        hold_cnt <= '0;
                    end
                end
                PH_HOLD_LOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_q  <= PH_RAMP_UP;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state_q <= PH_RAMP_UP;
            endcase
        end
    end

    assign phase = state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < level);
        end
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Self-checking bench for led_breath_pwm (PWM_BITS=4, HOLD_STEPS=2, SYNC_STAGES=2)
// against an arithmetic model of the breathing waveform indexed by accepted step count.
module tb_led_breath_pwm;

    localparam int MAXL   = 15;
    localparam int H      = 2;
    localparam int PERIOD = 2 * MAXL + 2 * H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       step_clock = 1'b0;
    logic       step_pulse;
    logic [3:0] level;
    logic [1:0] phase;
    logic       pwm_out;

    int total = 0;
    int bad   = 0;
    int acc_steps = 0;

    led_breath_pwm #(
        .PWM_BITS    (4),
        .HOLD_STEPS  (H),
        .SYNC_STAGES (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .step_clock (step_clock),
        .step_pulse (step_pulse),
        .level      (level),
        .phase      (phase),
        .pwm_out    (pwm_out)
    );

    always #5 clock = ~clock;

    function automatic int model_level(input int n);
        int m;
        m = n % PERIOD;
        if (m < MAXL) return m;
        if (m < MAXL + H) return MAXL;
        if (m < 2 * MAXL + H) return 2 * MAXL + H - m;
        return 0;
    endfunction

    function automatic int model_phase(input int n);
        int m;
        m = n % PERIOD;
        if (m < MAXL) return 0;
        if (m < MAXL + H) return 1;
        if (m < 2 * MAXL + H) return 2;
        return 3;
    endfunction

    function automatic int edge_pulses(input logic prev, input logic nxt);
        if (prev == nxt) return 0;
        if (nxt) return 1;
`ifdef LED_BREATH_BOTH_EDGES_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Drive one step_clock level, let it settle, and check pulses/level/phase.
    task automatic step_edge(input logic val, output int exp_p);
        int settle;
        int seen;
        exp_p = edge_pulses(step_clock, val);
        settle = $urandom_range(6, 12);
        step_clock = val;
        seen = 0;
        repeat (settle) begin
            @(negedge clock);
            if (step_pulse === 1'b1) seen++;
        end
        if (enable) acc_steps += exp_p;
        total++;
        if (seen !== exp_p) begin
            bad++;
            $display("FAIL pulse_count: got %0d expected %0d (steps=%0d)", seen, exp_p, acc_steps);
        end
        total++;
        if (level !== 4'(model_level(acc_steps))) begin
            bad++;
            $display("FAIL level: got %0d expected %0d (steps=%0d)", level, model_level(acc_steps), acc_steps);
        end
        total++;
        if (phase !== 2'(model_phase(acc_steps))) begin
            bad++;
            $display("FAIL phase: got %0d expected %0d (steps=%0d)", phase, model_phase(acc_steps), acc_steps);
        end
    endtask

    task automatic one_step();
        int p;
        p = 0;
        for (int i = 0; i < 4 && p == 0; i++) step_edge(~step_clock, p);
    endtask

    task automatic go_to(input int lvl, input int ph);
        int guard;
        guard = 0;
        while (!(model_level(acc_steps) == lvl && model_phase(acc_steps) == ph) && guard < PERIOD + 2) begin
            one_step();
            guard++;
        end
        total++;
        if (guard >= PERIOD + 2) begin
            bad++;
            $display("FAIL go_to: got guard %0d expected below %0d", guard, PERIOD + 2);
        end
    endtask

    task automatic apply_reset();
        step_clock = 1'b0;
        enable = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        acc_steps = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step_clock = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (step_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b expected 0", step_pulse); end
        total++;
        if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", level); end
        total++;
        if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        total++;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    endtask

    task automatic test_first_pulse();
        int p;
        reset_n = 1'b1;
        acc_steps = 0;
        repeat (9) @(negedge clock);
        step_clock = 1'b1;
        for (int k = 10; k <= 15; k++) begin
            @(negedge clock);
            total++;
            if (step_pulse !== (k == 13)) begin
                bad++;
                $display("FAIL first_pulse_edge%0d: got %b expected %b", k, step_pulse, (k == 13));
            end
        end
        acc_steps = 1;
        total++;
        if (level !== 4'd1 || phase !== 2'd0) begin
            bad++;
            $display("FAIL first_step_state: got level %0d phase %0d expected level 1 phase 0", level, phase);
        end
        step_edge(1'b0, p);
    endtask

    task automatic test_full_period();
        int lvl0;
        int ph0;
        lvl0 = model_level(acc_steps);
        ph0  = model_phase(acc_steps);
        for (int i = 0; i < PERIOD; i++) one_step();
        total++;
        if (level !== 4'(lvl0) || phase !== 2'(ph0)) begin
            bad++;
            $display("FAIL full_period: got level %0d phase %0d expected level %0d phase %0d", level, phase, lvl0, ph0);
        end
    endtask

    task automatic test_pwm(input int lvl, input int ph);
        int highs;
        go_to(lvl, ph);
        highs = 0;
        repeat (32) begin
            @(negedge clock);
            if (pwm_out === 1'b1) highs++;
        end
        total++;
        if (highs !== 2 * lvl) begin
            bad++;
            $display("FAIL pwm_duty_l%0d: got %0d highs expected %0d in 32 cycles", lvl, highs, 2 * lvl);
        end
    endtask

    task automatic test_enable();
        go_to(7, 0);
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) one_step();
        total++;
        if (level !== 4'd7 || phase !== 2'd0) begin
            bad++;
            $display("FAIL enable_freeze: got level %0d phase %0d expected level 7 phase 0", level, phase);
        end
        enable = 1'b1;
        one_step();
        total++;
        if (level !== 4'd8) begin
            bad++;
            $display("FAIL enable_resume: got %0d expected 8", level);
        end
    endtask

    task automatic test_random();
        int p;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) step_edge(step_clock, p);
            else step_edge(~step_clock, p);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        go_to(MAXL, 1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (level !== 4'd0 || pwm_out !== 1'b0 || step_pulse !== 1'b0 || phase !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: got level %0d pwm %b pulse %b phase %0d expected all 0",
                     level, pwm_out, step_pulse, phase);
        end
        apply_reset();
    endtask

    task automatic test_falling_edge();
        int p;
        step_edge(1'b1, p);
        step_edge(1'b0, p);
        total++;
`ifdef LED_BREATH_BOTH_EDGES_EN
        if (p !== 1) begin bad++; $display("FAIL falling_edge_model: got %0d expected 1", p); end
`else
        if (p !== 0) begin bad++; $display("FAIL falling_edge_model: got %0d expected 0", p); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_pulse();
        apply_reset();
        test_falling_edge();
        apply_reset();
        test_full_period();
        apply_reset();
        test_pwm(0, 0);
        test_pwm(5, 0);
        test_pwm(MAXL, 1);
        test_pwm(9, 2);
        apply_reset();
        test_enable();
        test_random();
        test_async_reset();
        test_full_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
